dense_readout_layer: RTL
========================

// Module: dense_readout_layer
// PURPOSE
//  Multi-output fixed-point readout layer: y[o] = sat(sum_h W[o][h]*x[h] + b[o]), o=0..OUTPUT_SZ-1.
//  Time-multiplexed MAC with LANES multipliers per cycle; weights/biases held in internal RAM.
//  Sits after the LSTM layer: consumes its hidden vector and replaces the single-output perceptron.
// PARAMETERS
//  HIDDEN_SZ  16  input vector length; must be a multiple of LANES
//  OUTPUT_SZ  4   number of outputs (>=1)
//  QN         6   integer bits of Q(QN.QM) two's-complement format
//  QM         11  fractional bits; BITWIDTH = QN+QM+1
//  LANES      4   parallel multipliers; K = HIDDEN_SZ/LANES MAC cycles per output
//  Derived: WADDR_W = clog2(OUTPUT_SZ*(HIDDEN_SZ+1)); ACC_W = 2*BITWIDTH+clog2(HIDDEN_SZ)+1
// PORTS
//  clock      in   1                   single clock, all logic on posedge
//  reset      in   1                   synchronous, active-high
//  hiddenVec  in   BITWIDTH*HIDDEN_SZ  x vector, element h at bits [h*BITWIDTH +: BITWIDTH]
//  start      in   1                   request a computation; sampled only while busy=0
//  wWe        in   1                   weight/bias write strobe
//  wAddr      in   WADDR_W             o*HIDDEN_SZ+h = W[o][h]; OUTPUT_SZ*HIDDEN_SZ+o = b[o]
//  wData      in   BITWIDTH            Q(QN.QM) weight or bias value
//  busy       out  1                   high from cycle after accepted start through the outValid cycle
//  outValid   out  1                   one-cycle pulse: outVec holds a new complete result
//  outVec     out  BITWIDTH*OUTPUT_SZ  y vector, element o at bits [o*BITWIDTH +: BITWIDTH]
// BEHAVIOUR
//  Reset: busy=0, outValid=0, outVec=0, FSM=IDLE, counters=0. Weight/bias RAM not cleared; retained.
//  FSM: IDLE -start-> MAC (hiddenVec latched on accept edge; later changes to hiddenVec ignored).
//   MAC: K cycles per output, LANES products/cycle into ACC_W signed accumulator -> FIN.
//   FIN: acc + (b[o] <<< QM); arithmetic >>> QM; saturate to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1];
//        write outVec slot o; if o==OUTPUT_SZ-1 -> DONE else o++, clear acc -> MAC.
//   DONE: outValid=1 for exactly 1 cycle, busy still 1 -> IDLE.
//  Latency: start accepted at edge 0 -> outValid high in cycle OUTPUT_SZ*(K+1)+1; busy drops next cycle.
//  outVec slots update progressively during a run; only the outValid-cycle value is guaranteed
//   coherent. outVec holds its value between runs.
//  Truncation toward -inf (no rounding). Products exact 2*BITWIDTH; no intermediate overflow.
//  start while busy=1: ignored, not queued. start in DONE cycle: ignored.
//  wWe while busy=1: write dropped. wWe with start same cycle in IDLE: write commits, run uses
//   the new value. wAddr >= OUTPUT_SZ*(HIDDEN_SZ+1): write ignored.
//  reset mid-run: abort at that edge, outputs return to reset values, no outValid pulse.
// CONFIGURATION
//  READOUT_SIGMOID_EN defined: FIN applies hard sigmoid after saturation:
//   y = clamp((y>>>2) + 0.5, 0, 1.0) i.e. in QM units clamp((y>>>2)+2^(QM-1), 0, 2^QM).
//   Same latency (combinational in FIN stage).
//  Undefined: linear saturated output as above.
// TESTING (QN=6,QM=11,HIDDEN_SZ=16,OUTPUT_SZ=2,LANES=4 -> K=4; 1.0=2048)
//  1 Reset: assert reset 2 cycles -> busy=0,outValid=0,outVec=0.
//  2 Basic: all W=2048, b=512, x=1024, start -> outValid in cycle 11, both y=16896 (8.25); busy low cycle 12.
//  3 Sat: W=65536(32.0), x=8192(4.0), b=0 -> y=131071; W=-65536 -> y=-131072 (0x20000).
//  4 Mixed: W[0][h]=2048, W[1][h]=-2048, x[h]=h*128, b=0 -> y0=15360, y1=-15360.
//  5 Hazards: start while busy and wWe while busy -> no second run, RAM unchanged (re-run gives same y);
//    reset at cycle 5 of run -> no outValid, outVec=0, next start runs normally.
//  6 READOUT_SIGMOID_EN: test 2 -> y=2048; W=0,b=0 -> y=1024; b=-16384 -> y=0.

Source files
------------

// File: rtl/dense_readout_layer_if.sv
// dense_readout_layer_if
//   Bundles the readout layer's data, control and weight-load signals.
//   master: drives hiddenVec, start, wWe, wAddr, wData; observes busy, outValid, outVec.
//   slave : the readout layer itself.
//   Parameters must match those given to dense_readout_layer.
interface dense_readout_layer_if #(
   parameter int HIDDEN_SZ = 16,
   parameter int OUTPUT_SZ = 4,
   parameter int QN        = 6,
   parameter int QM        = 11
);
   localparam int BITWIDTH = QN + QM + 1;
   localparam int WADDR_W  = $clog2(OUTPUT_SZ * (HIDDEN_SZ + 1));

   logic [BITWIDTH*HIDDEN_SZ-1:0] hiddenVec;
   logic                          start;
   logic                          wWe;
   logic [WADDR_W-1:0]            wAddr;
   logic [BITWIDTH-1:0]           wData;
   logic                          busy;
   logic                          outValid;
   logic [BITWIDTH*OUTPUT_SZ-1:0] outVec;

   modport master (
      output hiddenVec, start, wWe, wAddr, wData,
      input  busy, outValid, outVec
   );

   modport slave (
      input  hiddenVec, start, wWe, wAddr, wData,
      output busy, outValid, outVec
   );
endinterface

// File: rtl/dense_readout_layer.sv
// dense_readout_layer
//   Fixed-point readout layer: y[o] = sat(sum_h W[o][h]*x[h] + b[o]) in Q(QN.QM).
//   Time-multiplexed MAC, LANES products per cycle, HIDDEN_SZ/LANES cycles per output,
//   one finalisation cycle per output, one DONE cycle carrying outValid.
//   Weights/biases live in an internal register file written through wWe/wAddr/wData
//   (W[o][h] at o*HIDDEN_SZ+h, b[o] at OUTPUT_SZ*HIDDEN_SZ+o); not cleared by reset.
// Ports
//   clock  : single clock, posedge
//   reset  : synchronous, active-high
//   bus    : dense_readout_layer_if.slave (hiddenVec/start/weight port in, busy/outValid/outVec out)
// Build option
//   READOUT_SIGMOID_EN : hard sigmoid clamp((y>>>2)+0.5, 0, 1.0) applied after saturation.
module dense_readout_layer #(
   parameter int HIDDEN_SZ = 16,
   parameter int OUTPUT_SZ = 4,
   parameter int QN        = 6,
   parameter int QM        = 11,
   parameter int LANES     = 4
) (
   input  logic                clock,
   input  logic                reset,
   dense_readout_layer_if.slave bus
);
   localparam int BITWIDTH  = QN + QM + 1;
   localparam int K         = HIDDEN_SZ / LANES;
   localparam int NWORDS    = OUTPUT_SZ * (HIDDEN_SZ + 1);
   localparam int WADDR_W   = $clog2(NWORDS);
   localparam int ACC_W     = 2 * BITWIDTH + $clog2(HIDDEN_SZ) + 1;
   localparam int K_W       = (K > 1) ? $clog2(K) : 1;
   localparam int O_W       = (OUTPUT_SZ > 1) ? $clog2(OUTPUT_SZ) : 1;
   localparam int BIAS_BASE = OUTPUT_SZ * HIDDEN_SZ;

   localparam logic [K_W-1:0]       K_LAST  = K_W'(K - 1);
   localparam logic [O_W-1:0]       O_LAST  = O_W'(OUTPUT_SZ - 1);
   localparam logic [WADDR_W:0]     NW_LIM  = (WADDR_W + 1)'(NWORDS);
   localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - BITWIDTH){1'b0}}, {(BITWIDTH - 1){1'b1}}};
   localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W + 2 - BITWIDTH){1'b1}}, {(BITWIDTH - 1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MAC, FIN, DONE} state_t;
   state_t state, stateNext;

   logic signed [BITWIDTH-1:0]     wMem [NWORDS];
   logic [BITWIDTH*HIDDEN_SZ-1:0]  xReg;
   logic signed [ACC_W-1:0]        acc;
   logic signed [ACC_W-1:0]        laneSum;
   logic [K_W-1:0]                 kIdx;
   logic [O_W-1:0]                 oIdx;
   logic [BITWIDTH*OUTPUT_SZ-1:0]  outVecReg;

   logic [31:0]                    base;
   logic signed [BITWIDTH-1:0]     xElem;
   logic signed [2*BITWIDTH-1:0]   prod;
   logic signed [BITWIDTH-1:0]     bias;
   logic signed [ACC_W:0]          biased;
   logic signed [ACC_W:0]          shifted;
   logic signed [BITWIDTH-1:0]     ySat;
   logic signed [BITWIDTH-1:0]     yFin;

   assign bus.busy     = (state != IDLE);
   assign bus.outValid = (state == DONE);
   assign bus.outVec   = outVecReg;

   // Writes only land while idle; a write in the same cycle as an accepted start
   // commits at the accept edge, so the run sees it.
   always_ff @(posedge clock) begin
      if (bus.wWe && (state == IDLE) && ({1'b0, bus.wAddr} < NW_LIM))
         wMem[bus.wAddr] <= bus.wData;
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (bus.start) stateNext = MAC;
         MAC:     if (kIdx == K_LAST) stateNext = FIN;
         FIN:     stateNext = (oIdx == O_LAST) ? DONE : MAC;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // LANES products for output oIdx, hidden elements kIdx*LANES .. kIdx*LANES+LANES-1.
   always_comb begin
      laneSum = '0;
      xElem   = '0;
      prod    = '0;
      base    = 32'(oIdx) * HIDDEN_SZ + 32'(kIdx) * LANES;
      for (int unsigned l = 0; l < LANES; l++) begin
         xElem   = xReg[(32'(kIdx) * LANES + l) * BITWIDTH +: BITWIDTH];
         prod    = wMem[WADDR_W'(base + l)] * xElem;
         laneSum = laneSum + ACC_W'(prod);
      end
   end

   // Bias is aligned to the product scale (2*QM fraction bits) before the
   // truncating shift back to QM, so rounding is toward -inf on the full sum.
   always_comb begin
      bias    = wMem[WADDR_W'(BIAS_BASE + 32'(oIdx))];
      biased  = (ACC_W + 1)'(acc) + ((ACC_W + 1)'(bias) <<< QM);
      shifted = biased >>> QM;
      if (shifted > SAT_MAX)      ySat = {1'b0, {(BITWIDTH - 1){1'b1}}};
      else if (shifted < SAT_MIN) ySat = {1'b1, {(BITWIDTH - 1){1'b0}}};
      else                        ySat = shifted[BITWIDTH-1:0];
   end

`ifdef READOUT_SIGMOID_EN
   localparam logic signed [BITWIDTH:0] SIG_HALF = (BITWIDTH + 1)'(2 ** (QM - 1));
   localparam logic signed [BITWIDTH:0] SIG_ONE  = (BITWIDTH + 1)'(2 ** QM);
   logic signed [BITWIDTH:0] sig;

   always_comb begin
      sig = (BITWIDTH + 1)'(ySat >>> 2) + SIG_HALF;
      if (sig[BITWIDTH])     yFin = '0;
      else if (sig > SIG_ONE) yFin = SIG_ONE[BITWIDTH-1:0];
      else                   yFin = sig[BITWIDTH-1:0];
   end
`else
   always_comb yFin = ySat;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         xReg      <= '0;
         acc       <= '0;
         kIdx      <= '0;
         oIdx      <= '0;
         outVecReg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  xReg <= bus.hiddenVec;
                  acc  <= '0;
                  kIdx <= '0;
                  oIdx <= '0;
               end
            end
            MAC: begin
               acc  <= acc + laneSum;
               kIdx <= (kIdx == K_LAST) ? '0 : kIdx + 1'b1;
            end
            FIN: begin
               outVecReg[32'(oIdx) * BITWIDTH +: BITWIDTH] <= yFin;
               acc <= '0;
               if (oIdx != O_LAST) oIdx <= oIdx + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule
